router_fifo_sync: RTL and testbench
===================================

Name: router_fifo_sync

Overview:
Synchronizer and control glue between the 1x3 router's FSM and its three output FIFOs. It captures the 2-bit destination address at header time, steers the FSM write strobe to the selected FIFO, and multiplexes that FIFO's full flag back to the FSM. It derives per-channel valid-out from the FIFO empty flags and generates a per-channel soft reset when a destination leaves valid data unread for too long.

Parameters:
TIMEOUT, 30, number of consecutive cycles with vld_out_x=1 and read_enb_x=0 before soft_reset_x pulses (legal range 2..255).
CNT_W, 5, width of each timeout counter; must satisfy 2**CNT_W >= TIMEOUT.

Ports:
clock  input  1  single system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
detect_add  input  1  FSM header-detect strobe; latch data_in as address
data_in  input  2  destination address (00=ch0, 01=ch1, 10=ch2, 11=invalid)
write_enb_reg  input  1  FSM write request for the current packet
read_enb_0  input  1  destination 0 read enable
read_enb_1  input  1  destination 1 read enable
read_enb_2  input  1  destination 2 read enable
full_0  input  1  FIFO 0 full flag
full_1  input  1  FIFO 1 full flag
full_2  input  1  FIFO 2 full flag
empty_0  input  1  FIFO 0 empty flag
empty_1  input  1  FIFO 1 empty flag
empty_2  input  1  FIFO 2 empty flag
vld_out_0  output  1  FIFO 0 holds data
vld_out_1  output  1  FIFO 1 holds data
vld_out_2  output  1  FIFO 2 holds data
soft_reset_0  output  1  one-cycle timeout pulse, FIFO 0
soft_reset_1  output  1  one-cycle timeout pulse, FIFO 1
soft_reset_2  output  1  one-cycle timeout pulse, FIFO 2
fifo_full  output  1  full flag of the currently addressed FIFO
write_enb  output  3  one-hot write enable to FIFOs {2,1,0}

Behaviour:
- Reset is synchronous and active-high. At the rising edge with reset=1: addr register=00, all timeout counters=0, soft_reset_0..2=0.
- Address register:
  - Loads data_in on the rising edge when detect_add=1.
  - Holds its value otherwise.
  - If reset and detect_add are high together, reset wins.
- write_enb is combinational from addr and write_enb_reg:
  - write_enb_reg=0: 000.
  - write_enb_reg=1: addr 00 gives 001, 01 gives 010, 10 gives 100, 11 gives 000.
  - Reflects a new addr in the cycle after the detect_add edge.
- fifo_full is combinational: addr 00 gives full_0, 01 gives full_1, 10 gives full_2, 11 gives 0.
- vld_out_x = ~empty_x, combinational, independent of reset.
- Per-channel timeout, identical for x=0,1,2:
  - If vld_out_x=0 or read_enb_x=1: counter is cleared to 0 and soft_reset_x=0.
  - Otherwise, if counter==TIMEOUT-1: soft_reset_x=1 for that one cycle and counter is cleared to 0.
  - Otherwise: counter increments and soft_reset_x=0.
  - soft_reset_x rises at the edge that ends the TIMEOUT-th consecutive stalled cycle.
  - A continuous stall re-pulses every TIMEOUT cycles.
  - A single read_enb_x=1 cycle restarts the count.
- Channels are fully independent. Simultaneous timeouts on several channels pulse together.
- No output depends on the undefined value of data_in when detect_add=0.

Optional Feature:
Macro SYNC_SOFT_RESET_EN.
- Defined: timeout counters and soft_reset logic are present as described above.
- Undefined: counters are removed and soft_reset_0..2 are tied to constant 0. All other behaviour is unchanged.

Test Plan:
- Reset: hold reset=1 for 2 cycles with empty_x=1. Expect soft_reset_0..2=0, write_enb=000 (write_enb_reg=0), fifo_full=full_0, vld_out_0..2=0.
- Address steering: detect_add=1 with data_in=10 for one cycle, then write_enb_reg=1. Expect write_enb=100. Set full_2=1 and expect fifo_full=1; full_0=1 alone gives fifo_full=0. Repeat for 00 (001) and 01 (010). With data_in=11, expect write_enb=000 and fifo_full=0.
- Address hold: after latching 01, change data_in to 10 while detect_add=0. Expect write_enb to stay 010.
- Valid out: {empty_0,empty_1,empty_2}=110 gives {vld_out_0,vld_out_1,vld_out_2}=001 in the same cycle.
- Timeout: empty_2=0 and read_enb_2=0 held. soft_reset_2 is 0 for cycles 1..29 and 1 after the 30th edge, for exactly 1 cycle, then repeats 30 cycles later. Pulsing read_enb_2=1 at cycle 20 delays the pulse to 30 cycles after that read.
- Mid-count reset: assert reset at stall cycle 15. Counter restarts and the next soft_reset_2 comes 30 stalled cycles after reset deasserts. Build without SYNC_SOFT_RESET_EN and confirm soft_reset_x stays 0 throughout.

Source files
------------

// File: rtl/router_fifo_sync.sv
// router_fifo_sync: address latch, write steering, full mux, valid-out and
// per-channel read timeout soft reset for the 1x3 router FIFOs.
// Ports:
//   clock, reset (sync, active-high)
//   detect_add, data_in[1:0]: header strobe and destination address
//   write_enb_reg: FSM write request
//   read_enb_0..2: destination read enables
//   full_0..2, empty_0..2: FIFO status flags
//   vld_out_0..2: FIFO x holds data
//   soft_reset_0..2: one-cycle timeout pulse per FIFO
//   fifo_full: full flag of the addressed FIFO
//   write_enb[2:0]: one-hot FIFO write enable
// Build option: define SYNC_SOFT_RESET_EN to include the timeout counters;
// otherwise soft_reset_0..2 are constant 0.
module router_fifo_sync #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2,
  output logic       fifo_full,
  output logic [2:0] write_enb
);

  logic [1:0] addr;
  logic [2:0] sel;

  always_ff @(posedge clock) begin
    if (reset) begin
      addr <= 2'b00;
    end else if (detect_add) begin
      addr <= data_in;
    end
  end

  always_comb begin
    sel       = 3'b000;
    fifo_full = 1'b0;
    unique case (addr)
      2'b00: begin
        sel       = 3'b001;
        fifo_full = full_0;
      end
      2'b01: begin
        sel       = 3'b010;
        fifo_full = full_1;
      end
      2'b10: begin
        sel       = 3'b100;
        fifo_full = full_2;
      end
      default: begin
        sel       = 3'b000;
        fifo_full = 1'b0;
      end
    endcase
  end

  assign write_enb = write_enb_reg ? sel : 3'b000;

  assign vld_out_0 = ~empty_0;
  assign vld_out_1 = ~empty_1;
  assign vld_out_2 = ~empty_2;

`ifdef SYNC_SOFT_RESET_EN
  logic [2:0]       vld;
  logic [2:0]       rd;
  logic [2:0]       sr;
  logic [CNT_W-1:0] cnt [3];

  assign vld = {vld_out_2, vld_out_1, vld_out_0};
  assign rd  = {read_enb_2, read_enb_1, read_enb_0};

  for (genvar i = 0; i < 3; i++) begin : g_to
    // Counts consecutive stalled cycles; wraps to 0 on the pulse so a
    // continuous stall re-pulses every TIMEOUT cycles.
    always_ff @(posedge clock) begin
      if (reset) begin
        cnt[i] <= '0;
        sr[i]  <= 1'b0;
      end else if (!vld[i] || rd[i]) begin
        cnt[i] <= '0;
        sr[i]  <= 1'b0;
      end else if (cnt[i] == CNT_W'(TIMEOUT - 1)) begin
        cnt[i] <= '0;
        sr[i]  <= 1'b1;
      end else begin
        cnt[i] <= cnt[i] + 1'b1;
        sr[i]  <= 1'b0;
      end
    end
  end

  assign soft_reset_0 = sr[0];
  assign soft_reset_1 = sr[1];
  assign soft_reset_2 = sr[2];
`else
  logic unused_rd;
  assign unused_rd = ^{read_enb_0, read_enb_1, read_enb_2};

  assign soft_reset_0 = 1'b0;
  assign soft_reset_1 = 1'b0;
  assign soft_reset_2 = 1'b0;
`endif

endmodule

// File: tb/tb_router_fifo_sync.sv
// tb_router_fifo_sync: directed vector table plus timeout sequences
// for router_fifo_sync.
module tb_router_fifo_sync;

`ifdef SYNC_SOFT_RESET_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       full_0, full_1, full_2;
  logic       empty_0, empty_1, empty_2;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       fifo_full;
  logic [2:0] write_enb;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  router_fifo_sync #(.TIMEOUT(30), .CNT_W(5)) dut (
    .clock(clock),
    .reset(reset),
    .detect_add(detect_add),
    .data_in(data_in),
    .write_enb_reg(write_enb_reg),
    .read_enb_0(read_enb_0),
    .read_enb_1(read_enb_1),
    .read_enb_2(read_enb_2),
    .full_0(full_0),
    .full_1(full_1),
    .full_2(full_2),
    .empty_0(empty_0),
    .empty_1(empty_1),
    .empty_2(empty_2),
    .vld_out_0(vld_out_0),
    .vld_out_1(vld_out_1),
    .vld_out_2(vld_out_2),
    .soft_reset_0(soft_reset_0),
    .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2),
    .fifo_full(fifo_full),
    .write_enb(write_enb)
  );

  typedef struct {
    logic       det;
    logic [1:0] din;
    logic       wr;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] exp_we;
    logic       exp_ff;
    logic [2:0] exp_vld;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] sr_bus();
    return {soft_reset_2, soft_reset_1, soft_reset_0};
  endfunction

  function automatic logic [2:0] vld_bus();
    return {vld_out_2, vld_out_1, vld_out_0};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_cnt();
    read_enb_0 = 1'b1;
    read_enb_1 = 1'b1;
    read_enb_2 = 1'b1;
    empty_0 = 1'b1;
    empty_1 = 1'b1;
    empty_2 = 1'b1;
    tick();
  endtask

  initial begin
    // det din wr full empty exp_we exp_ff exp_vld  (bit x = channel x)
    tbl[0]  = '{1'b1, 2'b10, 1'b0, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000};
    tbl[1]  = '{1'b0, 2'b00, 1'b1, 3'b000, 3'b111, 3'b100, 1'b0, 3'b000};
    tbl[2]  = '{1'b0, 2'b00, 1'b1, 3'b100, 3'b111, 3'b100, 1'b1, 3'b000};
    tbl[3]  = '{1'b0, 2'b00, 1'b1, 3'b001, 3'b111, 3'b100, 1'b0, 3'b000};
    tbl[4]  = '{1'b1, 2'b00, 1'b1, 3'b001, 3'b111, 3'b001, 1'b1, 3'b000};
    tbl[5]  = '{1'b0, 2'b11, 1'b1, 3'b110, 3'b111, 3'b001, 1'b0, 3'b000};
    tbl[6]  = '{1'b1, 2'b01, 1'b1, 3'b010, 3'b111, 3'b010, 1'b1, 3'b000};
    tbl[7]  = '{1'b0, 2'b10, 1'b1, 3'b101, 3'b111, 3'b010, 1'b0, 3'b000};
    tbl[8]  = '{1'b0, 2'b10, 1'b0, 3'b010, 3'b111, 3'b000, 1'b1, 3'b000};
    tbl[9]  = '{1'b1, 2'b11, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000};
    tbl[10] = '{1'b0, 2'b00, 1'b1, 3'b000, 3'b011, 3'b000, 1'b0, 3'b100};
    tbl[11] = '{1'b1, 2'b10, 1'b1, 3'b100, 3'b000, 3'b100, 1'b1, 3'b111};

    // reset held two cycles; detect_add alongside must lose to reset
    reset = 1'b1;
    detect_add = 1'b1;
    data_in = 2'b10;
    write_enb_reg = 1'b0;
    {read_enb_2, read_enb_1, read_enb_0} = 3'b111;
    {full_2, full_1, full_0} = 3'b001;
    {empty_2, empty_1, empty_0} = 3'b111;
    tick();
    tick();
    chk("rst_soft_reset", 8'(sr_bus()), 8'h0);
    chk("rst_write_enb", 8'(write_enb), 8'h0);
    chk("rst_fifo_full", 8'(fifo_full), 8'h1);
    chk("rst_vld_out", 8'(vld_bus()), 8'h0);
    write_enb_reg = 1'b1;
    #1;
    chk("rst_addr_zero", 8'(write_enb), 8'h1);
    reset = 1'b0;
    detect_add = 1'b0;

    for (int i = 0; i < 12; i++) begin
      detect_add = tbl[i].det;
      data_in = tbl[i].din;
      write_enb_reg = tbl[i].wr;
      {full_2, full_1, full_0} = tbl[i].full;
      {empty_2, empty_1, empty_0} = tbl[i].empty;
      tick();
      chk($sformatf("v%0d_write_enb", i), 8'(write_enb), 8'(tbl[i].exp_we));
      chk($sformatf("v%0d_fifo_full", i), 8'(fifo_full), 8'(tbl[i].exp_ff));
      chk($sformatf("v%0d_vld_out", i), 8'(vld_bus()), 8'(tbl[i].exp_vld));
      chk($sformatf("v%0d_soft_reset", i), 8'(sr_bus()), 8'h0);
    end
    detect_add = 1'b0;

    // continuous stall on channel 2: pulses after edges 30 and 60
    clear_cnt();
    empty_2 = 1'b0;
    read_enb_2 = 1'b0;
    for (int k = 1; k <= 62; k++) begin
      tick();
      chk($sformatf("stall_e%0d", k), 8'(sr_bus()),
          8'({EN && (k == 30 || k == 60), 2'b00}));
    end

    // one read at edge 20 restarts the count: pulse at edge 50
    clear_cnt();
    empty_2 = 1'b0;
    read_enb_2 = 1'b0;
    for (int k = 1; k <= 55; k++) begin
      read_enb_2 = (k == 20);
      tick();
      chk($sformatf("read20_e%0d", k), 8'(sr_bus()),
          8'({EN && (k == 50), 2'b00}));
    end
    read_enb_2 = 1'b0;

    // reset at edge 16 mid-count: next pulse 30 stalled edges later
    clear_cnt();
    empty_2 = 1'b0;
    read_enb_2 = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      reset = (k == 16);
      tick();
      chk($sformatf("midrst_e%0d", k), 8'(sr_bus()),
          8'({EN && (k == 46), 2'b00}));
    end
    reset = 1'b0;

    // all channels stall together: simultaneous pulse at edge 30
    clear_cnt();
    {empty_2, empty_1, empty_0} = 3'b000;
    {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
    for (int k = 1; k <= 31; k++) begin
      tick();
      chk($sformatf("all_e%0d", k), 8'(sr_bus()),
          8'((EN && k == 30) ? 3'b111 : 3'b000));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
